// File: rtl/regfile_scoreboard.sv
// Parametrised 2R/1W register file with a per-entry pending-write scoreboard.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_address,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address_A,
    input  logic [ADDR_W-1:0] address_B,
    output logic [DATA_W-1:0] data_A,
    output logic [DATA_W-1:0] data_B,
    output logic              busy_A,
    output logic              busy_B
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic              wr_ok_c;
    logic              rsv_ok_c;
    logic [DATA_W-1:0] rd_data_a_c;
    logic [DATA_W-1:0] rd_data_b_c;
    logic              rd_busy_a_c;
    logic              rd_busy_b_c;

    // Entry 0 silently drops writes and reservations when it is the zero register.
    always_comb begin
        wr_ok_c  = wr_en;
        rsv_ok_c = rsv_en;
        if (ZERO_REG != 0) begin
            if (write_address == '0) wr_ok_c  = 1'b0;
            if (rsv_address == '0)   rsv_ok_c = 1'b0;
        end
    end

    // Reservation is applied after the write clear: the newer producer wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok_c)  busy_nxt[write_address] = 1'b0;
        if (rsv_ok_c) busy_nxt[rsv_address]   = 1'b1;
    end

    // Read-port sources: array contents, optionally overridden by the in-flight write.
    always_comb begin
        rd_data_a_c = mem[address_A];
        rd_data_b_c = mem[address_B];
`ifdef REGFILE_BYPASS_EN
        rd_busy_a_c = busy_nxt[address_A];
        rd_busy_b_c = busy_nxt[address_B];
        if (wr_ok_c && (write_address == address_A)) rd_data_a_c = write_data;
        if (wr_ok_c && (write_address == address_B)) rd_data_b_c = write_data;
`else
        rd_busy_a_c = busy[address_A];
        rd_busy_b_c = busy[address_B];
`endif
        if ((ZERO_REG != 0) && (address_A == '0)) begin
            rd_data_a_c = '0;
            rd_busy_a_c = 1'b0;
        end
        if ((ZERO_REG != 0) && (address_B == '0)) begin
            rd_data_b_c = '0;
            rd_busy_b_c = 1'b0;
        end
    end

    // Storage, scoreboard and registered read outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            busy   <= '0;
            data_A <= '0;
            data_B <= '0;
            busy_A <= 1'b0;
            busy_B <= 1'b0;
        end else begin
            if (wr_ok_c) mem[write_address] <= write_data;
            busy <= busy_nxt;
            if (rd_en) begin
                data_A <= rd_data_a_c;
                data_B <= rd_data_b_c;
                busy_A <= rd_busy_a_c;
                busy_B <= rd_busy_b_c;
            end
        end
    end

endmodule
